// File: rtl/ncpu32k_bus_arb.sv
// ---------------------------------------------------------------------------
// ncpu32k_bus_arb
//
// Purpose:
//   Two-master to one-slave arbiter for the ncpu32k handshake command bus.
//   The instruction bus (ibus, read-only) and the data bus (dbus) share a
//   single handshake_cmd_sram-style slave port, so one unified memory serves
//   both. Only one transaction is in flight at a time: a command on the A
//   channel, then its response on the B channel. A round-robin grant keeps
//   either bus from starving the other.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_ibus_A*/o_ibus_AREADY  ibus command channel (address + exception tag)
//   o_ibus_B*/i_ibus_BREADY  ibus response channel
//   i_dbus_A*/o_dbus_AREADY  dbus command channel (address, data, mask, tag)
//   o_dbus_B*/i_dbus_BREADY  dbus response channel
//   o_s_A*/i_s_AREADY        slave command channel
//   i_s_B*/o_s_BREADY        slave response channel
//
// Timing:
//   Arbitration takes one cycle in IDLE, so a slave command appears at the
//   earliest one cycle after the master raises AVALID. After a response
//   completes the arbiter spends one cycle in IDLE before the next grant.
//   Outputs toward the ungranted master are constant zero and never depend
//   on slave signals.
// ---------------------------------------------------------------------------
module ncpu32k_bus_arb #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 32
) (
    input  logic            clk,
    input  logic            rst,
    // ibus master
    input  logic            i_ibus_AVALID,
    output logic            o_ibus_AREADY,
    input  logic [AW-1:0]   i_ibus_AADDR,
    input  logic [1:0]      i_ibus_AEXC,
    output logic            o_ibus_BVALID,
    input  logic            i_ibus_BREADY,
    output logic [IW-1:0]   o_ibus_BDATA,
    output logic [1:0]      o_ibus_BEXC,
    // dbus master
    input  logic            i_dbus_AVALID,
    output logic            o_dbus_AREADY,
    input  logic [AW-1:0]   i_dbus_AADDR,
    input  logic [DW-1:0]   i_dbus_ADATA,
    input  logic [DW/8-1:0] i_dbus_AWMSK,
    input  logic [1:0]      i_dbus_AEXC,
    output logic            o_dbus_BVALID,
    input  logic            i_dbus_BREADY,
    output logic [IW-1:0]   o_dbus_BDATA,
    output logic [1:0]      o_dbus_BEXC,
    // slave port
    output logic            o_s_AVALID,
    input  logic            i_s_AREADY,
    output logic [AW-1:0]   o_s_AADDR,
    output logic [DW-1:0]   o_s_ADATA,
    output logic [DW/8-1:0] o_s_AWMSK,
    output logic [1:0]      o_s_AEXC,
    input  logic            i_s_BVALID,
    output logic            o_s_BREADY,
    input  logic [IW-1:0]   i_s_BDATA,
    input  logic [1:0]      i_s_BEXC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Master index 0 is ibus, 1 is dbus.
    localparam logic M_IBUS = 1'b0;
    localparam logic M_DBUS = 1'b1;

    state_t r_state;
    logic   r_grant;    // master currently owning the slave
    logic   r_last;     // master whose command was most recently accepted

    // Per-master views of the request side, indexed by master number.
    logic [1:0]    w_m_avalid;
    logic [1:0]    w_m_bready;
    logic [AW-1:0] w_m_addr [2];
    logic [1:0]    w_m_aexc [2];

    assign w_m_avalid = {i_dbus_AVALID, i_ibus_AVALID};
    assign w_m_bready = {i_dbus_BREADY, i_ibus_BREADY};
    assign w_m_addr[0] = i_ibus_AADDR;
    assign w_m_addr[1] = i_dbus_AADDR;
    assign w_m_aexc[0] = i_ibus_AEXC;
    assign w_m_aexc[1] = i_dbus_AEXC;

    logic w_sel_avalid;
    logic w_sel_bready;
    logic w_in_cmd;
    logic w_in_resp;

    assign w_sel_avalid = w_m_avalid[r_grant];
    assign w_sel_bready = w_m_bready[r_grant];

    // Outputs are forced quiet while reset is held, even though the state
    // register only clears on the reset edge.
    assign w_in_cmd  = !rst && (r_state == S_CMD);
    assign w_in_resp = !rst && (r_state == S_RESP);

    // -----------------------------------------------------------------------
    // Arbitration FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= M_IBUS;
            r_last  <= M_DBUS;      // ibus wins the first contention
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_m_avalid) begin
                        r_state <= S_CMD;
                        // Contention: favour the master that was not served
                        // last. Otherwise the single requester is bit 1's
                        // value (1 only when dbus alone is requesting).
                        if (&w_m_avalid) begin
                            r_grant <= ~r_last;
                        end else begin
                            r_grant <= w_m_avalid[1];
                        end
                    end
                end
                S_CMD: begin
                    if (w_sel_avalid && i_s_AREADY) begin
                        r_state <= S_RESP;
                        r_last  <= r_grant;
                    end else if (!w_sel_avalid) begin
                        // Withdrawn request: re-arbitrate, fairness untouched.
                        r_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (i_s_BVALID && w_sel_bready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Slave-side muxes
    // -----------------------------------------------------------------------
    assign o_s_AVALID = w_in_cmd && w_sel_avalid;
    assign o_s_AADDR  = w_in_cmd ? w_m_addr[r_grant] : '0;
    assign o_s_AEXC   = w_in_cmd ? w_m_aexc[r_grant] : 2'b00;
    // ibus never writes: its data and mask are tied off.
    assign o_s_ADATA  = (w_in_cmd && r_grant == M_DBUS) ? i_dbus_ADATA : '0;
    assign o_s_AWMSK  = (w_in_cmd && r_grant == M_DBUS) ? i_dbus_AWMSK : '0;
    assign o_s_BREADY = w_in_resp && w_sel_bready;

    // -----------------------------------------------------------------------
    // Master-side demux: only the owner sees slave activity.
    // -----------------------------------------------------------------------
    logic [1:0]    w_aready;
    logic [1:0]    w_bvalid;
    logic [IW-1:0] w_bdata [2];
    logic [1:0]    w_bexc  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            logic w_owner;
            assign w_owner      = (r_grant == 1'(gi));
            assign w_aready[gi] = w_in_cmd && w_owner && i_s_AREADY;
            assign w_bvalid[gi] = w_in_resp && w_owner && i_s_BVALID;
            assign w_bdata[gi]  = (w_in_resp && w_owner) ? i_s_BDATA : '0;
            assign w_bexc[gi]   = (w_in_resp && w_owner) ? i_s_BEXC : 2'b00;
        end
    endgenerate

    assign o_ibus_AREADY = w_aready[0];
    assign o_ibus_BVALID = w_bvalid[0];
    assign o_ibus_BDATA  = w_bdata[0];
    assign o_ibus_BEXC   = w_bexc[0];

    assign o_dbus_AREADY = w_aready[1];
    assign o_dbus_BVALID = w_bvalid[1];
    assign o_dbus_BDATA  = w_bdata[1];
    assign o_dbus_BEXC   = w_bexc[1];

endmodule

// File: tb/tb_ncpu32k_bus_arb.sv
module tb_ncpu32k_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ibus_AVALID, o_ibus_AREADY, o_ibus_BVALID, i_ibus_BREADY;
    logic [31:0] i_ibus_AADDR, o_ibus_BDATA;
    logic [1:0]  i_ibus_AEXC, o_ibus_BEXC;
    logic        i_dbus_AVALID, o_dbus_AREADY, o_dbus_BVALID, i_dbus_BREADY;
    logic [31:0] i_dbus_AADDR, i_dbus_ADATA, o_dbus_BDATA;
    logic [3:0]  i_dbus_AWMSK;
    logic [1:0]  i_dbus_AEXC, o_dbus_BEXC;
    logic        o_s_AVALID, i_s_AREADY, i_s_BVALID, o_s_BREADY;
    logic [31:0] o_s_AADDR, o_s_ADATA, i_s_BDATA;
    logic [3:0]  o_s_AWMSK;
    logic [1:0]  o_s_AEXC, i_s_BEXC;

    ncpu32k_bus_arb #(.AW(32), .DW(32), .IW(32)) dut (
        .clk(clk), .rst(rst),
        .i_ibus_AVALID(i_ibus_AVALID), .o_ibus_AREADY(o_ibus_AREADY),
        .i_ibus_AADDR(i_ibus_AADDR), .i_ibus_AEXC(i_ibus_AEXC),
        .o_ibus_BVALID(o_ibus_BVALID), .i_ibus_BREADY(i_ibus_BREADY),
        .o_ibus_BDATA(o_ibus_BDATA), .o_ibus_BEXC(o_ibus_BEXC),
        .i_dbus_AVALID(i_dbus_AVALID), .o_dbus_AREADY(o_dbus_AREADY),
        .i_dbus_AADDR(i_dbus_AADDR), .i_dbus_ADATA(i_dbus_ADATA),
        .i_dbus_AWMSK(i_dbus_AWMSK), .i_dbus_AEXC(i_dbus_AEXC),
        .o_dbus_BVALID(o_dbus_BVALID), .i_dbus_BREADY(i_dbus_BREADY),
        .o_dbus_BDATA(o_dbus_BDATA), .o_dbus_BEXC(o_dbus_BEXC),
        .o_s_AVALID(o_s_AVALID), .i_s_AREADY(i_s_AREADY),
        .o_s_AADDR(o_s_AADDR), .o_s_ADATA(o_s_ADATA), .o_s_AWMSK(o_s_AWMSK),
        .o_s_AEXC(o_s_AEXC), .i_s_BVALID(i_s_BVALID), .o_s_BREADY(o_s_BREADY),
        .i_s_BDATA(i_s_BDATA), .i_s_BEXC(i_s_BEXC)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Master agents (index 0 = ibus, 1 = dbus)
    bit          pend [2];
    logic [31:0] q_addr [2];
    logic [31:0] q_data [2];
    logic [3:0]  q_msk [2];
    logic [1:0]  q_exc [2];
    int          rep [2];
    int          brdy_mode [2];   // 0 = hold low, 1 = hold high, 2 = random
    logic        cur_bready [2];
    int          glog [$];        // order in which commands were accepted
    int          rcnt [2];

    // Slave model: a byte-maskable memory with a response delay
    logic [31:0] mem [logic [31:0]];
    bit          rand_mode = 0;
    bit          sl_busy = 0;
    int          sl_cnt = 0;
    int          sl_hold = 0;
    int          sl_delay = 1;
    int          sl_cmds = 0;
    logic [31:0] sl_rdata;
    logic [1:0]  sl_rexc;

    // Arbiter reference: who owns the slave and whether the command is done
    int m_owner = -1;      // -1 none, else master index
    bit m_resp  = 0;
    int m_last  = 1;
    int n_owner, n_last;
    bit n_resp;

    // Snapshots of DUT outputs taken mid-cycle
    logic        sv_savalid, sv_sbready, sv_sbvalid;
    logic [31:0] sv_saddr, sv_sdata;
    logic [3:0]  sv_smsk;
    logic [1:0]  sv_sexc;
    logic        sv_aready [2];
    logic        sv_bvalid [2];
    logic [31:0] sv_bdata [2];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_A5A5;
    endfunction

    // Expected outputs from the arbitration rules, given current inputs
    task automatic model_compare();
        logic [1:0]  av, br;
        logic [31:0] ad [2];
        logic [1:0]  ex [2];
        logic        e_ar [2], e_bv [2];
        logic [31:0] e_bd [2];
        logic [1:0]  e_be [2];
        logic        e_sav, e_sbr;
        logic        d_ar [2], d_bv [2];
        logic [31:0] d_bd [2];
        logic [1:0]  d_be [2];
        av = {i_dbus_AVALID, i_ibus_AVALID};
        br = {i_dbus_BREADY, i_ibus_BREADY};
        ad[0] = i_ibus_AADDR; ad[1] = i_dbus_AADDR;
        ex[0] = i_ibus_AEXC;  ex[1] = i_dbus_AEXC;
        d_ar[0] = o_ibus_AREADY; d_ar[1] = o_dbus_AREADY;
        d_bv[0] = o_ibus_BVALID; d_bv[1] = o_dbus_BVALID;
        d_bd[0] = o_ibus_BDATA;  d_bd[1] = o_dbus_BDATA;
        d_be[0] = o_ibus_BEXC;   d_be[1] = o_dbus_BEXC;
        e_sav = 0; e_sbr = 0;
        for (int m = 0; m < 2; m++) begin
            e_ar[m] = 0; e_bv[m] = 0; e_bd[m] = '0; e_be[m] = '0;
        end
        if (!rst && m_owner >= 0) begin
            if (!m_resp) begin
                e_sav = av[m_owner];
                e_ar[m_owner] = i_s_AREADY;
                chk("s_AADDR", o_s_AADDR, ad[m_owner]);
                chk("s_AEXC", o_s_AEXC, ex[m_owner]);
                chk("s_ADATA", o_s_ADATA, (m_owner == 1) ? i_dbus_ADATA : 32'h0);
                chk("s_AWMSK", o_s_AWMSK, (m_owner == 1) ? i_dbus_AWMSK : 4'h0);
            end else begin
                e_bv[m_owner] = i_s_BVALID;
                e_bd[m_owner] = i_s_BDATA;
                e_be[m_owner] = i_s_BEXC;
                e_sbr = br[m_owner];
            end
        end
        chk("s_AVALID", o_s_AVALID, e_sav);
        chk("s_BREADY", o_s_BREADY, e_sbr);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_AREADY", m), d_ar[m], e_ar[m]);
            chk($sformatf("m%0d_BVALID", m), d_bv[m], e_bv[m]);
            chk($sformatf("m%0d_BDATA", m), d_bd[m], e_bd[m]);
            chk($sformatf("m%0d_BEXC", m), d_be[m], e_be[m]);
        end
        // Next ownership
        n_owner = m_owner; n_resp = m_resp; n_last = m_last;
        if (rst) begin
            n_owner = -1; n_resp = 0; n_last = 1;
        end else if (m_owner < 0) begin
            if (av[0] && av[1]) n_owner = 1 - m_last;
            else if (av[0])     n_owner = 0;
            else if (av[1])     n_owner = 1;
            n_resp = 0;
        end else if (!m_resp) begin
            if (av[m_owner] && i_s_AREADY) begin
                n_resp = 1; n_last = m_owner;
            end else if (!av[m_owner]) begin
                n_owner = -1;
            end
        end else if (i_s_BVALID && br[m_owner]) begin
            n_owner = -1; n_resp = 0;
        end
    endtask

    // One clock cycle: drive, compare mid-cycle, then advance all models
    task automatic step();
        bit a_hs [2];
        bit b_hs [2];
        bit s_hs, sb_hs;
        if (rand_mode) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    pend[m]   = 1;
                    rep[m]    = 0;
                    q_addr[m] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                    q_data[m] = $urandom;
                    q_msk[m]  = (m == 1) ? 4'($urandom) : 4'h0;
                    q_exc[m]  = 2'($urandom);
                end else if (pend[m] && $urandom_range(0, 19) == 0) begin
                    pend[m] = 0;
                end
            end
        end
        for (int m = 0; m < 2; m++)
            cur_bready[m] = (brdy_mode[m] == 2) ? 1'($urandom) : (brdy_mode[m] == 1);
        i_ibus_AVALID = pend[0]; i_ibus_AADDR = q_addr[0]; i_ibus_AEXC = q_exc[0];
        i_ibus_BREADY = cur_bready[0];
        i_dbus_AVALID = pend[1]; i_dbus_AADDR = q_addr[1]; i_dbus_AEXC = q_exc[1];
        i_dbus_ADATA = q_data[1]; i_dbus_AWMSK = q_msk[1]; i_dbus_BREADY = cur_bready[1];
        i_s_AREADY = !sl_busy && sl_hold == 0 && (rand_mode ? 1'($urandom) : 1'b1);
        i_s_BVALID = sl_busy && sl_cnt == 0;
        i_s_BDATA  = i_s_BVALID ? sl_rdata : $urandom;
        i_s_BEXC   = i_s_BVALID ? sl_rexc : 2'($urandom);

        @(negedge clk);
        model_compare();
        sv_savalid = o_s_AVALID; sv_sbready = o_s_BREADY; sv_sbvalid = i_s_BVALID;
        sv_saddr = o_s_AADDR; sv_sdata = o_s_ADATA; sv_smsk = o_s_AWMSK; sv_sexc = o_s_AEXC;
        sv_aready[0] = o_ibus_AREADY; sv_aready[1] = o_dbus_AREADY;
        sv_bvalid[0] = o_ibus_BVALID; sv_bvalid[1] = o_dbus_BVALID;
        sv_bdata[0] = o_ibus_BDATA;   sv_bdata[1] = o_dbus_BDATA;
        for (int m = 0; m < 2; m++) begin
            a_hs[m] = pend[m] && sv_aready[m];
            b_hs[m] = sv_bvalid[m] && cur_bready[m];
        end
        s_hs  = sv_savalid && i_s_AREADY;
        sb_hs = i_s_BVALID && sv_sbready;

        @(posedge clk);
        m_owner = n_owner; m_resp = n_resp; m_last = n_last;
        if (rst) begin
            sl_busy = 0; sl_hold = 0; pend[0] = 0; pend[1] = 0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (a_hs[m]) begin
                    glog.push_back(m);
                    if (rep[m] > 0) begin
                        rep[m]--; q_addr[m] += 4;
                    end else begin
                        pend[m] = 0;
                    end
                end
                if (b_hs[m]) rcnt[m]++;
            end
            if (sb_hs) sl_busy = 0;
            if (s_hs) begin
                logic [31:0] w;
                sl_busy  = 1;
                sl_cnt   = rand_mode ? int'($urandom_range(0, 3)) : sl_delay;
                sl_cmds++;
                sl_rdata = mem_rd(sv_saddr);
                sl_rexc  = rand_mode ? 2'($urandom) : sv_sexc;
                w = sl_rdata;
                for (int b = 0; b < 4; b++)
                    if (sv_smsk[b]) w[8*b +: 8] = sv_sdata[8*b +: 8];
                if (sv_smsk != 0) mem[sv_saddr] = w;
            end else if (sl_busy && sl_cnt > 0) begin
                sl_cnt--;
            end
            if (sl_hold > 0) sl_hold--;
        end
        #1;
    endtask

    task automatic wait_resp(input int m, input string nm, output logic [31:0] d);
        bit seen = 0;
        bit other = 0;
        d = '0;
        for (int k = 0; k < 50 && !seen; k++) begin
            step();
            if (sv_bvalid[1-m]) other = 1;
            if (sv_bvalid[m] && cur_bready[m]) begin
                seen = 1; d = sv_bdata[m];
            end
        end
        chk({nm, "_done"}, seen, 1);
        chk({nm, "_other_bvalid"}, other, 0);
        $display("txn %s master %0d data %08h", nm, m, d);
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        logic [31:0] d;
        int          exp_alt [6] = '{0, 1, 0, 1, 0, 1};
        int          c0, k;
        bit          ok;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; q_addr[m] = 0; q_data[m] = 0; q_msk[m] = 0; q_exc[m] = 0;
            rep[m] = 0; brdy_mode[m] = 1; rcnt[m] = 0;
        end
        mem[32'h100] = 32'h1234_5678;
        rst = 1;
        step(); step();
        chk("rst_s_AVALID", sv_savalid, 0);
        chk("rst_ibus_AREADY", sv_aready[0], 0);
        chk("rst_dbus_BVALID", sv_bvalid[1], 0);
        rst = 0;
        step();
        chk("idle_s_AVALID", sv_savalid, 0);
        $display("txn reset done");

        // Single ibus read
        pend[0] = 1; q_addr[0] = 32'h100; q_exc[0] = 2'b01;
        step();
        chk("t1_arb_cycle_s_AVALID", sv_savalid, 0);
        step();
        chk("t1_s_AVALID", sv_savalid, 1);
        chk("t1_s_AADDR", sv_saddr, 32'h100);
        chk("t1_s_AWMSK", sv_smsk, 4'h0);
        wait_resp(0, "t1_ibus_read", d);
        chk("t1_BDATA", d, 32'h1234_5678);

        // dbus write then read-back
        pend[1] = 1; q_addr[1] = 32'h200; q_data[1] = 32'hDEAD_BEEF; q_msk[1] = 4'hF; q_exc[1] = 0;
        wait_resp(1, "t2_dbus_write", d);
        pend[1] = 1; q_msk[1] = 4'h0; q_data[1] = 32'h0;
        wait_resp(1, "t2_dbus_read", d);
        chk("t2_readback", d, 32'hDEAD_BEEF);

        // Simultaneous requests from reset, then continuous alternation
        do_reset();
        glog.delete(); rcnt[0] = 0; rcnt[1] = 0;
        pend[0] = 1; q_addr[0] = 32'h300; pend[1] = 1; q_addr[1] = 32'h400; q_msk[1] = 0;
        for (k = 0; k < 100 && !(rcnt[0] >= 1 && rcnt[1] >= 1); k++) step();
        chk("t3_pair_done", (rcnt[0] >= 1 && rcnt[1] >= 1), 1);
        chk("t3_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);
        chk("t3_second_grant", (glog.size() > 1) ? glog[1] : -1, 1);
        glog.delete(); rcnt[0] = 0; rcnt[1] = 0;
        rep[0] = 2; rep[1] = 2; pend[0] = 1; pend[1] = 1;
        for (k = 0; k < 200 && !(rcnt[0] >= 3 && rcnt[1] >= 3); k++) step();
        chk("t3_alt_done", glog.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_alt_grant%0d", i), (glog.size() > i) ? glog[i] : -1, exp_alt[i]);
        $display("txn alternation grants %p", glog);

        // Back-pressure on dbus response
        brdy_mode[1] = 0; pend[1] = 1; q_addr[1] = 32'h200; q_msk[1] = 0;
        ok = 0;
        for (k = 0; k < 30 && !ok; k++) begin step(); ok = sv_sbvalid; end
        chk("t4_s_BVALID_seen", ok, 1);
        pend[0] = 1; q_addr[0] = 32'h100; rep[0] = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_s_BREADY", sv_sbready, 0);
            chk("t4_hold_ibus_AREADY", sv_aready[0], 0);
            chk("t4_hold_dbus_BVALID", sv_bvalid[1], 1);
        end
        brdy_mode[1] = 1;
        step();
        chk("t4_complete", sv_bvalid[1] && sv_sbready, 1);
        chk("t4_complete_data", sv_bdata[1], 32'hDEAD_BEEF);
        step();
        chk("t4_arb_cycle_s_AVALID", sv_savalid, 0);
        step();
        chk("t4_ibus_s_AVALID", sv_savalid, 1);
        chk("t4_ibus_s_AADDR", sv_saddr, 32'h100);
        wait_resp(0, "t4_ibus_after_bp", d);

        // Reset while an ibus response is outstanding
        brdy_mode[0] = 0; pend[0] = 1; q_addr[0] = 32'h104;
        ok = 0;
        for (k = 0; k < 30 && !ok; k++) begin step(); ok = sv_bvalid[0]; end
        chk("t5_in_resp", ok, 1);
        brdy_mode[0] = 1;
        do_reset();
        step();
        chk("t5_ibus_AREADY", sv_aready[0], 0);
        chk("t5_dbus_AREADY", sv_aready[1], 0);
        chk("t5_ibus_BVALID", sv_bvalid[0], 0);
        chk("t5_dbus_BVALID", sv_bvalid[1], 0);
        chk("t5_s_AVALID", sv_savalid, 0);
        glog.delete(); rcnt[0] = 0; rcnt[1] = 0;
        pend[0] = 1; q_addr[0] = 32'h100; pend[1] = 1; q_addr[1] = 32'h200; q_msk[1] = 0;
        for (k = 0; k < 100 && !(rcnt[0] >= 1 && rcnt[1] >= 1); k++) step();
        chk("t5_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);

        // Slave command back-pressure
        c0 = sl_cmds;
        sl_hold = 4; pend[1] = 1; q_addr[1] = 32'h208; q_msk[1] = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_s_AVALID", sv_savalid, 1);
            chk("t6_s_AADDR", sv_saddr, 32'h208);
            chk("t6_dbus_AREADY", sv_aready[1], 0);
        end
        step();
        chk("t6_accept", sv_aready[1], 1);
        wait_resp(1, "t6_dbus_read", d);
        chk("t6_one_cmd", sl_cmds - c0, 1);

        // Randomized traffic with occasional resets and withdrawn requests
        do_reset();
        rand_mode = 1; brdy_mode[0] = 2; brdy_mode[1] = 2;
        glog.delete(); rcnt[0] = 0; rcnt[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0;
        $display("txn random phase grants %0d ibus_resp %0d dbus_resp %0d",
                 glog.size(), rcnt[0], rcnt[1]);
        chk("rand_progress", (rcnt[0] > 20 && rcnt[1] > 20), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
